// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/data memory arbiter.
package mem_arb_pkg;

    localparam int unsigned DEFAULT_READ_LAT     = 32'd2;
    localparam int unsigned DEFAULT_STARVE_LIMIT = 32'd4;
    localparam int unsigned STARVE_W             = 32'd3;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } port_e;

    typedef struct packed {
        logic  valid;
        port_e port;
    } resp_tag_t;

    localparam resp_tag_t TAG_NONE = '{valid: 1'b0, port: PORT_IF};

    // Drops the valid bit of a tag that belongs to the port being flushed.
    function automatic resp_tag_t flush_tag(input resp_tag_t tag,
                                            input logic      flush,
                                            input port_e     flush_port);
        resp_tag_t res;
        res = tag;
        if (flush && (tag.port == flush_port)) begin
            res.valid = 1'b0;
        end else begin
            res.valid = tag.valid;
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_resp_pipe.sv
// Shift register of response tags that follows each read through the fixed
// memory latency; the tail names the requester owning the current read word.
module mem_resp_pipe
    import mem_arb_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_READ_LAT
) (
    input  logic      clk_i,
    input  logic      rst_n_i,
    input  resp_tag_t push_i,
    input  logic      flush_i,
    input  port_e     flush_port_i,
    output resp_tag_t tail_o
);

    resp_tag_t tag_q [DEPTH];
    resp_tag_t tag_d [DEPTH];

    // Next stage contents: shift by one, flushing the selected port everywhere.
    always_comb begin
        tag_d[0] = flush_tag(push_i, flush_i, flush_port_i);
        for (int i = 1; i < int'(DEPTH); i++) begin
            tag_d[i] = flush_tag(tag_q[i-1], flush_i, flush_port_i);
        end
    end

    // Tag storage; reset drops every in-flight response.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                tag_q[i] <= TAG_NONE;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    // A flush arriving with the response still suppresses it.
    assign tail_o = flush_tag(tag_q[DEPTH-1], flush_i, flush_port_i);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory between fetch and load/store: data-first arbitration with
// a fetch starvation guard, memory muxing, and in-order read response routing.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned READ_LAT     = DEFAULT_READ_LAT,
    parameter int unsigned STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    input  logic        if_flush_i,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic        d_gnt_o,
    output logic        d_rvalid_o,
    output logic [31:0] d_rdata_o,
    output logic        mem_read_en_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    logic [STARVE_W-1:0] starve_q;
    logic [STARVE_W-1:0] starve_d;
    logic                fetch_first_s;
    logic                if_gnt_s;
    logic                d_gnt_s;
    resp_tag_t           push_s;
    resp_tag_t           tail_s;

    // Grants are gated by reset so every output is quiet while rst_n is low.
    assign fetch_first_s = if_req_i && (starve_q == LIMIT);
    assign if_gnt_s      = rst_n_i && if_req_i && (!d_req_i || fetch_first_s);
    assign d_gnt_s       = rst_n_i && d_req_i && !fetch_first_s;

    // Starvation counter next state: count data wins while fetch waits.
    always_comb begin
        starve_d = starve_q;
        if (!if_req_i || if_gnt_s) begin
            starve_d = '0;
        end else if (d_gnt_s && (starve_q != LIMIT)) begin
            starve_d = starve_q + 3'd1;
        end else begin
            starve_d = starve_q;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    // Memory drive from the winner; everything idles to zero without a grant.
    always_comb begin
        mem_addr_o    = 32'd0;
        mem_wdata_o   = 32'd0;
        mem_read_en_o = 1'b0;
        mem_we_o      = 1'b0;
        push_s        = TAG_NONE;
        if (d_gnt_s) begin
            mem_addr_o    = d_addr_i;
            mem_wdata_o   = d_we_i ? d_wdata_i : 32'd0;
            mem_read_en_o = !d_we_i;
            mem_we_o      = d_we_i;
            push_s        = '{valid: !d_we_i, port: PORT_D};
        end else if (if_gnt_s) begin
            mem_addr_o    = if_addr_i;
            mem_read_en_o = 1'b1;
            push_s        = '{valid: 1'b1, port: PORT_IF};
        end else begin
            push_s        = TAG_NONE;
        end
    end

    mem_resp_pipe #(
        .DEPTH        (READ_LAT)
    ) u_resp_pipe (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .push_i       (push_s),
        .flush_i      (if_flush_i),
        .flush_port_i (PORT_IF),
        .tail_o       (tail_s)
    );

    assign if_gnt_o    = if_gnt_s;
    assign d_gnt_o     = d_gnt_s;
    assign if_rvalid_o = tail_s.valid && (tail_s.port == PORT_IF);
    assign d_rvalid_o  = tail_s.valid && (tail_s.port == PORT_D);
    assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : 32'd0;
    assign d_rdata_o   = d_rvalid_o  ? mem_rdata_i : 32'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table of per-cycle grant vectors, directed flush and
// reset sequences, and a response scoreboard fed by a behavioural memory.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, if_flush, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_read_en, mem_we;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.READ_LAT(2), .STARVE_LIMIT(4)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata), .if_flush_i(if_flush),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
        .mem_read_en_o(mem_read_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    // Behavioural 256x32 memory with a two-cycle read pipe.
    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    logic [31:0] rd_s0 = 32'd0;
    logic [31:0] rd_s1 = 32'd0;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
        rd_s0 <= mem_read_en ? mem[mem_addr[9:2]] : 32'd0;
        rd_s1 <= rd_s0;
        cyc   <= cyc + 1;
    end
    assign mem_rdata = rd_s1;

    typedef struct {
        logic        port_d;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t sb[$];

    // Response monitor: every rvalid must match the oldest expected read.
    always begin
        exp_t e;
        logic [31:0] got;
        @(negedge clk);
        #2;
        n_cmp++;
        if (if_rvalid && d_rvalid) begin
            n_fail++;
            $display("FAIL rvalid_both: got if_rvalid=1 d_rvalid=1, expected at most one (cycle %0d)", cyc);
        end else if (if_rvalid || d_rvalid) begin
            got = d_rvalid ? d_rdata : if_rdata;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL rvalid_unexpected: got port_d=%0b data=%h, expected no response (cycle %0d)", d_rvalid, got, cyc);
            end else begin
                e = sb.pop_front();
                if (d_rvalid !== e.port_d || got !== e.data || cyc != e.due) begin
                    n_fail++;
                    $display("FAIL rvalid_match: got port_d=%0b data=%h cycle=%0d, expected port_d=%0b data=%h cycle=%0d",
                             d_rvalid, got, cyc, e.port_d, e.data, e.due);
                end
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            n_fail++;
            $display("FAIL rvalid_missing: got no rvalid at cycle %0d, expected port_d=%0b data=%h", cyc, e.port_d, e.data);
        end
        n_cmp++;
        if ((!if_rvalid && if_rdata !== 32'd0) || (!d_rvalid && d_rdata !== 32'd0)) begin
            n_fail++;
            $display("FAIL rdata_idle: got if_rdata=%h d_rdata=%h, expected 0 when not valid", if_rdata, d_rdata);
        end
    end

    // Drive one cycle, check grants and memory drive, and record expected reads.
    task automatic step(input string nm, input logic ifr, input logic [31:0] ifa,
                        input logic dr, input logic dwe, input logic [31:0] da,
                        input logic [31:0] dwd, input logic fl,
                        input logic exp_ig, input logic exp_dg, input logic keep);
        logic [3:0]  exp_v;
        logic [31:0] exp_addr;
        @(negedge clk);
        if_req = ifr; if_addr = ifa; d_req = dr; d_we = dwe;
        d_addr = da; d_wdata = dwd; if_flush = fl;
        #1;
        exp_v    = {exp_ig, exp_dg, exp_ig | (exp_dg & ~dwe), exp_dg & dwe};
        exp_addr = exp_dg ? da : (exp_ig ? ifa : 32'd0);
        n_cmp++;
        if ({if_gnt, d_gnt, mem_read_en, mem_we} !== exp_v) begin
            n_fail++;
            $display("FAIL %s strobes: got {if_gnt,d_gnt,re,we}=%b, expected %b", nm,
                     {if_gnt, d_gnt, mem_read_en, mem_we}, exp_v);
        end
        n_cmp++;
        if (mem_addr !== exp_addr) begin
            n_fail++;
            $display("FAIL %s mem_addr: got %h, expected %h", nm, mem_addr, exp_addr);
        end
        if (exp_dg && dwe) begin
            n_cmp++;
            if (mem_wdata !== dwd) begin
                n_fail++;
                $display("FAIL %s mem_wdata: got %h, expected %h", nm, mem_wdata, dwd);
            end
            ref_mem[da[9:2]] = dwd;
        end
        if (exp_ig && keep) sb.push_back('{1'b0, ref_mem[ifa[9:2]], cyc + 2});
        if (exp_dg && !dwe && keep) sb.push_back('{1'b1, ref_mem[da[9:2]], cyc + 2});
    endtask

    task automatic check_quiet(input string nm);
        logic [199:0] outs;
        outs = {if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
                mem_read_en, mem_we, mem_addr, mem_wdata};
        n_cmp++;
        if (outs !== 200'd0) begin
            n_fail++;
            $display("FAIL %s: got outputs=%h, expected all zero", nm, outs);
        end
    endtask

    typedef struct {
        string       nm;
        logic        ifr;
        logic [31:0] ifa;
        logic        dr;
        logic        dwe;
        logic [31:0] da;
        logic [31:0] dwd;
        logic        exp_ig;
        logic        exp_dg;
    } vec_t;
    vec_t vt[14];

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = {16'hC0DE, 8'h00, i[7:0]};
            ref_mem[i] = {16'hC0DE, 8'h00, i[7:0]};
        end
        mem[4]     = 32'hDEADBEEF;
        ref_mem[4] = 32'hDEADBEEF;

        vt[0]  = '{"idle",       1'b0, 32'h00, 1'b0, 1'b0, 32'h00, 32'h00, 1'b0, 1'b0};
        vt[1]  = '{"if_only_10", 1'b1, 32'h10, 1'b0, 1'b0, 32'h00, 32'h00, 1'b1, 1'b0};
        vt[2]  = '{"d_rd_20",    1'b0, 32'h00, 1'b1, 1'b0, 32'h20, 32'h00, 1'b0, 1'b1};
        vt[3]  = '{"both_c0",    1'b1, 32'h14, 1'b1, 1'b0, 32'h20, 32'h00, 1'b0, 1'b1};
        vt[4]  = '{"both_c1",    1'b1, 32'h14, 1'b1, 1'b0, 32'h20, 32'h00, 1'b0, 1'b1};
        vt[5]  = '{"both_c2",    1'b1, 32'h14, 1'b1, 1'b0, 32'h20, 32'h00, 1'b0, 1'b1};
        vt[6]  = '{"both_c3",    1'b1, 32'h14, 1'b1, 1'b0, 32'h20, 32'h00, 1'b0, 1'b1};
        vt[7]  = '{"both_c4",    1'b1, 32'h14, 1'b1, 1'b0, 32'h20, 32'h00, 1'b1, 1'b0};
        vt[8]  = '{"both_c5",    1'b1, 32'h18, 1'b1, 1'b0, 32'h20, 32'h00, 1'b0, 1'b1};
        vt[9]  = '{"d_wr_40",    1'b0, 32'h00, 1'b1, 1'b1, 32'h40, 32'h55, 1'b0, 1'b1};
        vt[10] = '{"d_rd_40",    1'b0, 32'h00, 1'b1, 1'b0, 32'h40, 32'h00, 1'b0, 1'b1};
        vt[11] = '{"if_only_44", 1'b1, 32'h44, 1'b0, 1'b0, 32'h00, 32'h00, 1'b1, 1'b0};
        vt[12] = '{"both_wr_48", 1'b1, 32'h18, 1'b1, 1'b1, 32'h48, 32'h77, 1'b0, 1'b1};
        vt[13] = '{"idle_end",   1'b0, 32'h00, 1'b0, 1'b0, 32'h00, 32'h00, 1'b0, 1'b0};

        rst_n = 1'b0; if_req = 1'b0; if_flush = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'd0;
        repeat (2) @(negedge clk);
        #1 check_quiet("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            step(vt[i].nm, vt[i].ifr, vt[i].ifa, vt[i].dr, vt[i].dwe, vt[i].da,
                 vt[i].dwd, 1'b0, vt[i].exp_ig, vt[i].exp_dg, 1'b1);
        end
        repeat (2) step("idle", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Flush lands with the third fetch grant and with the first response.
        step("fl_if_0", 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("fl_if_4", 1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("fl_if_8", 1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        step("fl_d_40", 1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        repeat (2) step("idle", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("post_fl_if_c", 1'b1, 32'hC, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (3) step("idle", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Saturate the starvation counter, then reset with reads in flight.
        repeat (4) step("pre_rst_both", 1'b1, 32'h14, 1'b1, 1'b0, 32'h24, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1 check_quiet("reset_midflight");
        sb.delete();
        @(negedge clk);
        #1 check_quiet("reset_held");
        if_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step("post_rst_idle", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("post_rst_both", 1'b1, 32'h14, 1'b1, 1'b0, 32'h28, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (4) step("drain", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d responses outstanding, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
